cpu_run_controller: RTL and testbench

Sequences the RISC-V core on the DE10-Nano board. It replaces the free-running clock divider and the raw key-to-reset path with a single 50 MHz clock domain: the CPU is driven by a clock-enable strobe. The block debounces the board keys and switch, holds the CPU in reset for a fixed window, and runs, halts or single-steps the core at a selectable rate. It also counts the cycles the core has been enabled.

---
 rtl/cpu_ctrl_pkg.sv | 14 +
 rtl/key_debouncer.sv | 63 ++++++
 rtl/cpu_run_controller.sv | 153 +++++++++++++++
 tb/tb_cpu_run_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run controller: FSM state encodings and
// the synchronizer depth used on every raw board input.
package cpu_ctrl_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_HALTED     = 2'd1,
        ST_STEP       = 2'd2,
        ST_RUNNING    = 2'd3
    } run_state_e;

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes one raw asynchronous board input, debounces it with a
// stable-sample counter and emits a one-cycle strobe on each accepted 1->0 edge.
module key_debouncer
    import cpu_ctrl_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   level_q, level_d;
    logic                   fall_q;
    logic [CW-1:0]          count_q, count_d;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Counter only runs while the input disagrees with the accepted level;
    // any agreeing sample restarts the stability window.
    always_comb begin
        level_d = level_q;
        count_d = '0;
        if (synced != level_q) begin
            if (count_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = synced;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q <= RESET_LEVEL;
            count_q <= '0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            count_q <= count_d;
            fall_q  <= level_q & ~level_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Runs, halts, single-steps and resets the soft core from debounced board
// controls, advancing it with a clock-enable strobe in the 50 MHz domain.
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RESET_HOLD      = 16,
    parameter int DIV_BASE_LOG2   = 10,
    parameter int CNT_W           = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_reset_n,
    input  logic             key_step_n,
    input  logic             run_sw,
    input  logic [1:0]       speed_sel,
    output logic             cpu_reset,
    output logic             cpu_enable,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] tick_count
);

    localparam int PW = DIV_BASE_LOG2 + 6;
    localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [PW-1:0] ONES = '1;

    logic resetKeyLevel, resetStrobe;
    logic stepKeyLevel, stepStrobe;
    logic runLevel, runFall;
    logic unusedLevels;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_resetKey (
        .clock(clock), .reset(reset), .raw_i(key_reset_n),
        .level_o(resetKeyLevel), .fall_o(resetStrobe)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_stepKey (
        .clock(clock), .reset(reset), .raw_i(key_step_n),
        .level_o(stepKeyLevel), .fall_o(stepStrobe)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_runSwitch (
        .clock(clock), .reset(reset), .raw_i(run_sw),
        .level_o(runLevel), .fall_o(runFall)
    );

    assign unusedLevels = ^{resetKeyLevel, stepKeyLevel, runFall};

    logic [SYNC_STAGES-1:0][1:0] speedSync_q;
    logic [1:0]                  speedSync;
    logic [PW-1:0]               presc_q;
    logic [PW-1:0]               tickMask;
    logic                        tick;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            speedSync_q <= '0;
            presc_q     <= '0;
        end else begin
            speedSync_q <= {speedSync_q[SYNC_STAGES-2:0], speed_sel};
            presc_q     <= presc_q + 1'b1;
        end
    end

    // Each speed step widens the all-ones window by two bits (4x slower).
    assign speedSync = speedSync_q[SYNC_STAGES-1];
    assign tickMask  = ONES >> {2'd3 - speedSync, 1'b0};
    assign tick      = &(presc_q | ~tickMask);

    run_state_e state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          holdDone;

    assign holdDone = (hold_q == HW'(RESET_HOLD - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET_HOLD;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        if (resetStrobe) begin
            state_d = ST_RESET_HOLD;
        end else begin
            case (state_q)
                ST_RESET_HOLD: begin
                    if (holdDone) begin
                        state_d = runLevel ? ST_RUNNING : ST_HALTED;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (runLevel) begin
                        state_d = ST_RUNNING;
                    end else if (stepStrobe) begin
                        state_d = ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (tick) state_d = ST_HALTED;
                end
                ST_RUNNING: begin
                    if (!runLevel) state_d = ST_HALTED;
                end
                default: state_d = ST_RESET_HOLD;
            endcase
        end
    end

    logic             cpuReset_q, cpuReset_d;
    logic             cpuEnable_q, cpuEnable_d;
    logic [CNT_W-1:0] tickCount_q, tickCount_d;

    // Enable is suppressed whenever the next state is the reset hold, so the
    // core never sees an advance strobe while it is being reset.
    always_comb begin
        cpuReset_d  = (state_d == ST_RESET_HOLD);
        cpuEnable_d = tick && !resetStrobe &&
                      ((state_q == ST_STEP) || (state_q == ST_RUNNING));
        tickCount_d = tickCount_q;
        if (cpuReset_d) begin
            tickCount_d = '0;
        end else if (cpuEnable_d) begin
            tickCount_d = tickCount_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpuReset_q  <= 1'b1;
            cpuEnable_q <= 1'b0;
            tickCount_q <= '0;
        end else begin
            cpuReset_q  <= cpuReset_d;
            cpuEnable_q <= cpuEnable_d;
            tickCount_q <= tickCount_d;
        end
    end

    assign cpu_reset  = cpuReset_q;
    assign cpu_enable = cpuEnable_q;
    assign state      = state_q;
    assign tick_count = tickCount_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomized scoreboard bench for cpu_run_controller: a window-based
// reference model predicts every state/reset sample and every enable pulse.
module tb_cpu_run_controller;

    localparam int DEB  = 4;
    localparam int HOLD = 4;
    localparam int DIVL = 2;
    localparam int CW   = 8;
    localparam int MAXE = 20000;

    localparam int M_HOLD = 0;
    localparam int M_HALT = 1;
    localparam int M_STEP = 2;
    localparam int M_RUN  = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          keyResetN = 1'b1;
    logic          keyStepN = 1'b1;
    logic          runSw = 1'b0;
    logic [1:0]    speedSel = 2'd0;
    logic          cpuReset;
    logic          cpuEnable;
    logic [1:0]    stateOut;
    logic [CW-1:0] tickCount;

    cpu_run_controller #(
        .DEBOUNCE_CYCLES(DEB), .RESET_HOLD(HOLD), .DIV_BASE_LOG2(DIVL), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset),
        .key_reset_n(keyResetN), .key_step_n(keyStepN), .run_sw(runSw),
        .speed_sel(speedSel),
        .cpu_reset(cpuReset), .cpu_enable(cpuEnable),
        .state(stateOut), .tick_count(tickCount)
    );

    always #5 clock = ~clock;

    typedef struct { int st; int rst; } status_t;
    typedef struct { int cyc; int cnt; } pulse_t;

    status_t statusQ[$];
    pulse_t  pulseQ[$];
    int total = 0;
    int bad = 0;
    int cycleNo = 0;

    int hist [4][MAXE];
    int mEdge, mMode, mHold, mCnt;
    int lvlR, lvlS, lvlRun, strR, strS;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Synchronized value the DUT logic sees in the cycle before edge e.
    function automatic int syncBefore(input int which, input int e, input int rl);
        return (e >= 3) ? hist[which][e-3] : rl;
    endfunction

    // Level flips once the last DEB synchronized samples all disagree with it.
    function automatic int debounced(input int which, input int lvl, input int rl);
        for (int i = 0; i < DEB; i++) begin
            int e = mEdge - i;
            if (e < 1) return lvl;
            if (syncBefore(which, e, rl) == lvl) return lvl;
        end
        return 1 - lvl;
    endfunction

    function automatic void modelReset();
        mEdge = 0; mMode = M_HOLD; mHold = 0; mCnt = 0;
        lvlR = 1; lvlS = 1; lvlRun = 0; strR = 0; strS = 0;
        statusQ.delete();
        pulseQ.delete();
    endfunction

    function automatic void modelEdge();
        int spd, tick, en, next, nR, nS;
        mEdge++;
        hist[0][mEdge-1] = int'(keyResetN);
        hist[1][mEdge-1] = int'(keyStepN);
        hist[2][mEdge-1] = int'(runSw);
        hist[3][mEdge-1] = int'(speedSel);
        spd  = syncBefore(3, mEdge, 0);
        tick = ((mEdge % (1 << (DIVL + 2*spd))) == 0) ? 1 : 0;
        en   = 0;
        next = mMode;
        if (strR != 0) begin
            next = M_HOLD; mHold = 0; mCnt = 0;
        end else begin
            case (mMode)
                M_HOLD: begin
                    mHold++;
                    if (mHold == HOLD) begin
                        mHold = 0;
                        next = (lvlRun != 0) ? M_RUN : M_HALT;
                    end
                end
                M_HALT: begin
                    if (lvlRun != 0) next = M_RUN;
                    else if (strS != 0) next = M_STEP;
                end
                M_STEP: begin
                    if (tick != 0) begin en = 1; next = M_HALT; end
                end
                default: begin
                    if (tick != 0) en = 1;
                    if (lvlRun == 0) next = M_HALT;
                end
            endcase
        end
        if (en != 0) begin
            mCnt = (mCnt + 1) % (1 << CW);
            pulseQ.push_back('{mEdge, mCnt});
        end
        mMode = next;
        statusQ.push_back('{next, (next == M_HOLD) ? 1 : 0});
        nR = debounced(0, lvlR, 1);
        nS = debounced(1, lvlS, 1);
        strR = (lvlR == 1 && nR == 0) ? 1 : 0;
        strS = (lvlS == 1 && nS == 0) ? 1 : 0;
        lvlR = nR;
        lvlS = nS;
        lvlRun = debounced(2, lvlRun, 0);
    endfunction

    task automatic stepCycle();
        @(posedge clock);
        modelEdge();
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic rN, input logic sN, input logic run,
                                 input logic [1:0] spd, input int n);
        keyResetN = rN;
        keyStepN  = sN;
        runSw     = run;
        speedSel  = spd;
        repeat (n) stepCycle();
    endtask

    task automatic checkResetValues();
        checkOutput("rstCpuReset", int'(cpuReset), 1);
        checkOutput("rstCpuEnable", int'(cpuEnable), 0);
        checkOutput("rstState", int'(stateOut), M_HOLD);
        checkOutput("rstTickCount", int'(tickCount), 0);
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) cycleNo <= 0;
        else cycleNo <= cycleNo + 1;
    end

    // Monitor: consumes one status entry per cycle and one pulse entry per enable.
    always @(negedge clock) begin
        status_t s;
        pulse_t  p;
        if (reset) begin
            checkOutput("enableInReset", int'(cpuEnable), 0);
        end else begin
            checkOutput("enableDuringCpuReset", int'(cpuEnable & cpuReset), 0);
            if (statusQ.size() > 0) begin
                s = statusQ.pop_front();
                checkOutput("state", int'(stateOut), s.st);
                checkOutput("cpuReset", int'(cpuReset), s.rst);
            end
            if (cpuEnable) begin
                checkOutput("pulseExpected", (pulseQ.size() > 0) ? 1 : 0, 1);
                if (pulseQ.size() > 0) begin
                    p = pulseQ.pop_front();
                    checkOutput("pulseCycle", cycleNo, p.cyc);
                    checkOutput("tickCount", int'(tickCount), p.cnt);
                end
            end else if (pulseQ.size() > 0 && pulseQ[0].cyc <= cycleNo) begin
                checkOutput("missedPulse", int'(cpuEnable), 1);
                void'(pulseQ.pop_front());
            end
        end
    end

    initial begin
        modelReset();
        repeat (2) @(negedge clock);
        checkResetValues();
        #2 reset = 1'b0;

        applyStimulus(1, 1, 0, 0, 200);

        for (int k = 0; k < 4; k++) begin
            logic [1:0] spd;
            spd = 2'($urandom_range(0, 3));
            applyStimulus(1, 1, 0, spd, 5);
            applyStimulus(1, 0, 0, spd, 10);
            applyStimulus(1, 1, 0, spd, 280);
        end

        applyStimulus(1, 1, 1, 0, 60);
        applyStimulus(1, 1, 1, 1, 200);
        applyStimulus(1, 1, 0, 1, 20);

        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 0, 0, $urandom_range(1, 3));
            applyStimulus(1, 1, 0, 0, 10);
        end

        applyStimulus(1, 1, 1, 0, 30);
        applyStimulus(0, 1, 1, 0, $urandom_range(5, 12));
        applyStimulus(1, 1, 1, 0, 40);

        repeat (300) begin
            applyStimulus(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 1)),
                          logic'($urandom_range(0, 1)), 2'($urandom_range(0, 1)),
                          $urandom_range(1, 12));
        end

        // Long fast run after a reset press so the 8-bit counter wraps.
        applyStimulus(1, 1, 1, 0, 20);
        applyStimulus(0, 1, 1, 0, 8);
        applyStimulus(1, 1, 1, 0, 1100);

        applyStimulus(1, 1, 0, 3, 30);
        applyStimulus(1, 0, 0, 3, 10);
        for (int k = 0; k < 10 && mMode != M_STEP; k++) stepCycle();
        #2 reset = 1'b1;
        #1 checkResetValues();
        checkOutput("pulsesPendingAtReset", pulseQ.size(), 0);
        modelReset();
        keyStepN = 1'b1;
        repeat (3) @(negedge clock);
        checkResetValues();
        #2 reset = 1'b0;
        applyStimulus(1, 1, 0, 0, 30);

        checkOutput("pulsesPendingAtEnd", pulseQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
